// File: rtl/if_stage.sv
// rtl/if_stage.sv - MIPS instruction-fetch stage: PC, IF/ID register, redirect and fetch counter
module if_stage #(
    parameter logic [31:0] RESET_PC   = 32'h00000000,
    parameter logic [31:0] EXC_VECTOR = 32'h80000004
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_instr,
    input  logic        stall,
    input  logic        flush,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    input  logic        exc_valid,
    output logic        if_id_valid,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_pc_plus4,
    output logic [31:0] if_id_instr,
    output logic [31:0] fetch_count
);

    typedef enum logic {
        BOOT,
        RUN
    } state_t;

    state_t      state;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        unused_target_bits;

    // pc is only ever loaded with word-aligned values, so it drives the ROM directly
    assign imem_addr          = pc;
    assign pc_plus4           = pc + 32'd4;
    assign unused_target_bits = ^redirect_target[1:0];

    // PC, boot sequencing and IF/ID register with exception > redirect > flush > stall priority
    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= BOOT;
            pc             <= {RESET_PC[31:2], 2'b00};
            if_id_valid    <= 1'b0;
            if_id_pc       <= 32'h0;
            if_id_pc_plus4 <= 32'h0;
            if_id_instr    <= 32'h0;
            fetch_count    <= 32'h0;
        end else begin
            case (state)
                BOOT: begin
                    // one bubble cycle while the ROM address settles at the reset PC
                    state       <= RUN;
                    if_id_valid <= 1'b0;
                    if_id_instr <= 32'h0;
                end
                default: begin
                    if (exc_valid) begin
                        pc          <= {EXC_VECTOR[31:2], 2'b00};
                        if_id_valid <= 1'b0;
                        if_id_instr <= 32'h0;
                    end else if (redirect_valid) begin
                        pc          <= {redirect_target[31:2], 2'b00};
                        if_id_valid <= 1'b0;
                        if_id_instr <= 32'h0;
                    end else if (flush) begin
                        // flush always bubbles IF/ID; the PC still respects stall
                        if (!stall) begin
                            pc <= pc_plus4;
                        end
                        if_id_valid <= 1'b0;
                        if_id_instr <= 32'h0;
                    end else if (!stall) begin
                        pc             <= pc_plus4;
                        if_id_valid    <= 1'b1;
                        if_id_pc       <= pc;
                        if_id_pc_plus4 <= pc_plus4;
                        if_id_instr    <= imem_instr;
                        if (fetch_count != 32'hFFFFFFFF) begin
                            fetch_count <= fetch_count + 32'd1;
                        end
                    end
                end
            endcase
        end
    end

endmodule
